rr_mux_reg: RTL and testbench

//  Parametrised N:1 datapath mux with valid/ready handshake, round-robin or fixed-priority arbitration and
//  a registered output stage. Generalises the 2:1 combinational mux used in the pipelined core.
//  It merges several requesters onto one shared path, e.g. multiple result/writeback sources or memory

---
 rtl/mux_pkg.sv | 5 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/rr_mux_reg.sv | 68 ++++++
 tb/tb_rr_mux_reg.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared arbitration types and limits for the N:1 registered mux
package mux_pkg;
    typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_t;
    localparam int MAX_MUX_N = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin / fixed-priority grant with its own rotating pointer
// Ports: req (N requests), mode (RR or fixed), advance (a transfer happened),
//        gnt (one-hot), gnt_idx (granted index, 0 when idle), any_gnt
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = ($clog2(N) > 0) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  arb_mode_t        mode,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any_gnt
);
    logic [SEL_W-1:0] ptr_d, ptr_q;
    always_comb begin
        int c;
        c       = 0;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        // scan N slots starting at ptr (RR) or 0 (fixed), wrapping without a modulo
        for (int k = 0; k < N; k++) begin
            c = (mode == ARB_FIXED) ? k : int'(ptr_q) + k;
            c = (c >= N) ? c - N : c;
            if (!any_gnt && req[c]) begin
                gnt[c]  = 1'b1;
                gnt_idx = SEL_W'(c);
                any_gnt = 1'b1;
            end
        end
        ptr_d = (advance && mode == ARB_RR) ?
                ((int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
endmodule

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N:1 valid/ready mux with RR or fixed-priority arbitration and a registered output
// Ports: prio_mode (0 RR, 1 fixed), in_valid/in_data/in_ready per channel,
//        out_valid/out_data/out_src registered output, out_ready downstream accept
module rr_mux_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = ($clog2(N) > 0) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  prio_mode,
    input  logic [N-1:0]          in_valid,
    input  logic [N-1:0][WIDTH-1:0] in_data,
    output logic [N-1:0]          in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_src,
    input  logic                  out_ready
);
    logic             can_load, load, any_gnt;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] sel_data;
    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_data_d, out_data_q;
    logic [SEL_W-1:0] out_src_d, out_src_q;

    rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (in_valid),
        .mode    (arb_mode_t'(prio_mode)),
        .advance (load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    always_comb begin
        can_load = !out_valid_q || out_ready;
        load     = can_load && any_gnt;
        in_ready = (reset_n && can_load) ? gnt : '0;
        // AND-OR mux on the one-hot grant; yields 0 rather than X when idle
        sel_data = '0;
        for (int i = 0; i < N; i++) sel_data = sel_data | (in_data[i] & {WIDTH{gnt[i]}});
        out_valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_data_d  = load ? sel_data : out_data_q;
        out_src_d   = load ? gnt_idx : out_src_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: randomized scoreboard bench for rr_mux_reg against a behavioural model
module tb_rr_mux_reg;
    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   prio_mode = 1'b0;
    logic [N-1:0]           in_valid = '0;
    logic [N-1:0][WIDTH-1:0] in_data = '0;
    logic [N-1:0]           in_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [SEL_W-1:0]       out_src;
    logic                   out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [N-1:0]            pending = '0;
    logic [WIDTH-1:0]        pdata [N];
    logic [WIDTH+SEL_W-1:0]  sb [$];
    logic                    m_valid = 1'b0;
    logic [WIDTH-1:0]        m_data = '0;
    logic [SEL_W-1:0]        m_src = '0;
    int                      m_ptr = 0;

    rr_mux_reg #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .prio_mode (prio_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // which requester wins: first requester in service order (from ptr, or from 0 when fixed)
    function automatic int model_grant(input logic [N-1:0] v, input int ptr, input logic fixed);
        for (int k = 0; k < N; k++) begin
            int c = fixed ? k : (ptr + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // one clock cycle: dm 0 = random data, 1 = 0x10+i, 2 = dv
    task automatic step(input logic [N-1:0] req, input logic pm, input logic ordy,
                        input int dm, input logic [WIDTH-1:0] dv);
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            if (!pending[i] && req[i]) begin
                pending[i] = 1'b1;
                pdata[i] = (dm == 0) ? $urandom : (dm == 1) ? WIDTH'(32'h10 + i) : dv;
            end
        for (int i = 0; i < N; i++) in_data[i] = pending[i] ? pdata[i] : $urandom;
        in_valid = pending;
        prio_mode = pm;
        out_ready = ordy;
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_src", 64'(out_src), 64'(m_src));
        chk("in_ready_onehot0", 64'($onehot0(in_ready)), 64'd1);
        g = model_grant(pending, m_ptr, pm);
        exp_rdy = (g >= 0 && (!m_valid || ordy)) ? N'(1) << g : '0;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (exp_rdy != '0) begin
            sb.push_back({pdata[g], SEL_W'(g)});
            m_valid = 1'b1;
            m_data = pdata[g];
            m_src = SEL_W'(g);
            pending[g] = 1'b0;
            if (!pm) m_ptr = (g + 1) % N;
        end else if (ordy) m_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data = '0;
        m_src = '0;
        m_ptr = 0;
        sb.delete();
    endtask

    task automatic report(input string name, input int f0);
        if (failures == f0) $display("%s: TEST PASSED", name);
        else $display("%s: Error (%0d)", name, failures - f0);
    endtask

    // monitor: every accepted output item must match the oldest expected transfer
    initial forever begin
        logic [WIDTH+SEL_W-1:0] e;
        @(negedge clk);
        #3;
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%h/%0d expected=none", out_data, out_src);
            end else begin
                e = sb.pop_front();
                if ({out_data, out_src} !== e) begin
                    failures++;
                    $display("FAIL sb_item actual=%h/%0d expected=%h/%0d",
                             out_data, out_src, e[WIDTH+SEL_W-1:SEL_W], e[SEL_W-1:0]);
                end
            end
        end
    end

    initial begin
        int f0;
        logic pm;
        for (int i = 0; i < N; i++) pdata[i] = '0;
        // reset with every channel requesting
        f0 = failures;
        pending = '1;
        for (int i = 0; i < N; i++) pdata[i] = WIDTH'(32'h10 + i);
        in_valid = pending;
        for (int i = 0; i < N; i++) in_data[i] = pdata[i];
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        report("reset", f0);

        f0 = failures;
        repeat (6) step('1, 1'b0, 1'b1, 1, '0);
        report("rr_fairness", f0);

        f0 = failures;
        repeat (4) step(4'b1010, 1'b1, 1'b1, 0, '0);
        repeat (3) step(4'b1000, 1'b1, 1'b1, 0, '0);
        report("fixed_priority", f0);

        f0 = failures;
        repeat (N + 2) step('0, 1'b0, 1'b1, 0, '0);
        step(4'b0100, 1'b0, 1'b1, 2, 32'hDEAD);
        repeat (3) step(4'b0001, 1'b0, 1'b0, 0, '0);
        step('0, 1'b0, 1'b1, 0, '0);
        step('0, 1'b0, 1'b1, 0, '0);
        report("backpressure", f0);

        f0 = failures;
        repeat (N + 2) step('0, 1'b0, 1'b1, 0, '0);
        step(4'b0100, 1'b0, 1'b1, 0, '0);
        step(4'b1001, 1'b0, 1'b1, 0, '0);
        step(4'b1001, 1'b0, 1'b1, 0, '0);
        step(4'b1001, 1'b0, 1'b1, 0, '0);
        repeat (3) step(4'b1001, 1'b1, 1'b1, 0, '0);
        step(4'b0110, 1'b0, 1'b1, 0, '0);
        step(4'b0110, 1'b0, 1'b1, 0, '0);
        report("wrap_mode_switch", f0);

        f0 = failures;
        repeat (N + 2) step('0, 1'b0, 1'b1, 0, '0);
        step(4'b0010, 1'b0, 1'b1, 0, '0);
        step('0, 1'b0, 1'b0, 0, '0);
        step('0, 1'b0, 1'b0, 0, '0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) step('1, 1'b0, 1'b1, 0, '0);
        report("reset_mid_stall", f0);

        f0 = failures;
        pm = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 15) == 0) pm = ~pm;
            step(N'($urandom), pm, $urandom_range(0, 3) != 0, 0, '0);
        end
        repeat (N + 3) step('0, 1'b0, 1'b1, 0, '0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        report("random", f0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
